// File: rtl/memory_control.sv
// Arbiter between the icache and dcache for a single RAM port.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | no grant; one arbitration cycle before any RAM drive
// DGRANT | dcache owns the RAM until BLOCK_WORDS beats or it drops
// IGRANT | icache owns the RAM for a single word
//
// After a dcache block, a competing icache request wins the next
// arbitration so that back-to-back dcache traffic cannot starve it.
module memory_control #(
    parameter int BLOCK_WORDS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             iREN,
    input  logic [31:0]      iaddr,
    output logic             iwait,
    output logic [31:0]      iload,
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [31:0]      daddr,
    input  logic [31:0]      dstore,
    output logic             dwait,
    output logic [31:0]      dload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic [1:0]       ramstate,
    output logic [CNT_W-1:0] access_cnt
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    // Wide enough to hold BLOCK_WORDS itself, never narrower than 2 bits.
    localparam int BEAT_W = ($clog2(BLOCK_WORDS + 1) < 2) ? 2 : $clog2(BLOCK_WORDS + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_nxt, beat_inc;
    logic              d_last, d_last_nxt;
    logic              ram_access;
    logic              d_req;

    assign ram_access = (ramstate == RAM_ACCESS);
    assign d_req      = dREN | dWEN;
    assign beat_inc   = beat_cnt + 1'b1;

    // State, beat counter and anti-starvation flag registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            beat_cnt <= '0;
            d_last   <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            d_last   <= d_last_nxt;
        end
    end

    // Completed RAM accesses; wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK) begin
        if (RST) begin
            access_cnt <= '0;
        end else if ((state == DGRANT || state == IGRANT) && ram_access) begin
            access_cnt <= access_cnt + 1'b1;
        end
    end

    // Arbitration, grant release and RAM/cache output muxing.
    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        d_last_nxt = d_last;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                beat_nxt = '0;
                if (d_req && !(iREN && d_last)) begin
                    state_nxt  = DGRANT;
                    d_last_nxt = 1'b1;
                end else if (iREN) begin
                    state_nxt  = IGRANT;
                    d_last_nxt = 1'b0;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = ramload;
                dwait    = ~ram_access;
                if (ram_access) begin
                    beat_nxt = beat_inc;
                end
                // Address changes alone never end the grant; only the beat
                // count or the request dropping does.
                if (!d_req || (ram_access && beat_inc == BEAT_LAST)) begin
                    state_nxt = IDLE;
                    beat_nxt  = '0;
                end
            end
            IGRANT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = ramload;
                iwait   = ~ram_access;
                if (!iREN || ram_access) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_memory_control.sv
// Bench for memory_control: directed scenarios with literal expectations,
// plus a per-cycle comparison against an ownership-level arbiter model.
module tb_memory_control;

    localparam int BW  = 2;
    localparam int CW  = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          iREN;
    logic [31:0]   iaddr;
    logic          iwait;
    logic [31:0]   iload;
    logic          dREN, dWEN;
    logic [31:0]   daddr, dstore;
    logic          dwait;
    logic [31:0]   dload;
    logic          ramREN, ramWEN;
    logic [31:0]   ramaddr, ramstore, ramload;
    logic [1:0]    ramstate;
    logic [CW-1:0] access_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    memory_control #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .access_cnt(access_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the RAM (0 none, 1 dcache, 2 icache), words moved in
    // the current dcache block, whether the dcache was served last, and the
    // total number of completed RAM words.
    int m_owner   = 0;
    int m_words   = 0;
    bit m_d_last  = 0;
    int m_total   = 0;
    bit m_valid   = 0;

    always @(posedge CLK) begin
        bit acc, dq;
        acc = (ramstate == 2'd2);
        dq  = dREN | dWEN;
        if (RST) begin
            m_owner = 0; m_words = 0; m_d_last = 0; m_total = 0; m_valid = 1;
        end else if (m_owner == 0) begin
            if (dq && !(iREN && m_d_last)) begin
                m_owner = 1; m_d_last = 1;
            end else if (iREN) begin
                m_owner = 2; m_d_last = 0;
            end
        end else if (m_owner == 1) begin
            if (acc) begin
                m_total = (m_total + 1) % (1 << CW);
                m_words++;
            end
            if (!dq || m_words == BW) begin
                m_owner = 0; m_words = 0;
            end
        end else begin
            if (acc) m_total = (m_total + 1) % (1 << CW);
            if (!iREN || acc) m_owner = 0;
        end
    end

    always @(negedge CLK) begin
        logic e_ren, e_wen, e_iw, e_dw;
        logic [31:0] e_addr, e_store, e_il, e_dl;
        if (m_valid) begin
            e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
            e_iw = 1; e_dw = 1; e_il = 0; e_dl = 0;
            if (m_owner == 1) begin
                e_addr = daddr; e_store = dstore;
                e_wen = dWEN; e_ren = dREN && !dWEN;
                e_dl = ramload; e_dw = (ramstate != 2'd2);
            end else if (m_owner == 2) begin
                e_ren = 1; e_addr = iaddr; e_il = ramload;
                e_iw = (ramstate != 2'd2);
            end
            chk("m_ramREN",   32'(ramREN),   32'(e_ren));
            chk("m_ramWEN",   32'(ramWEN),   32'(e_wen));
            chk("m_ramaddr",  ramaddr,       e_addr);
            chk("m_ramstore", ramstore,      e_store);
            chk("m_iwait",    32'(iwait),    32'(e_iw));
            chk("m_dwait",    32'(dwait),    32'(e_dw));
            chk("m_iload",    iload,         e_il);
            chk("m_dload",    dload,         e_dl);
            chk("m_cnt",      32'(access_cnt), 32'(m_total));
        end
    end

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1; iREN = 0; iaddr = 0; dREN = 0; dWEN = 0; daddr = 0;
        dstore = 0; ramload = 0; ramstate = 2'd0;
        repeat (2) next_cycle;
        @(negedge CLK);
        chk("rst_iwait", 32'(iwait), 1);
        chk("rst_dwait", 32'(dwait), 1);
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_cnt", 32'(access_cnt), 0);

        // Icache read, RAM answers on the third cycle.
        next_cycle; RST = 0; iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
        @(negedge CLK); chk("i_arb_ramREN", 32'(ramREN), 0);
        next_cycle;
        @(negedge CLK);
        chk("i_ramREN", 32'(ramREN), 1);
        chk("i_ramaddr", ramaddr, 32'h40);
        chk("i_busy_iwait", 32'(iwait), 1);
        next_cycle; ramstate = 2'd2; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        chk("i_acc_iwait", 32'(iwait), 0);
        chk("i_iload", iload, 32'hDEADBEEF);
        next_cycle; iREN = 0; ramstate = 2'd0;
        @(negedge CLK);
        chk("i_cnt", 32'(access_cnt), 1);

        // Dcache 2-word writeback; icache request arrives mid-block.
        next_cycle; dWEN = 1; daddr = 32'h100; dstore = 32'h11111111; ramstate = 2'd2;
        @(negedge CLK); chk("wb_arb_ramWEN", 32'(ramWEN), 0);
        next_cycle; iREN = 1; iaddr = 32'h80;
        @(negedge CLK);
        chk("wb0_ramWEN", 32'(ramWEN), 1);
        chk("wb0_addr", ramaddr, 32'h100);
        chk("wb0_dwait", 32'(dwait), 0);
        next_cycle; daddr = 32'h104; dstore = 32'h22222222;
        @(negedge CLK);
        chk("wb1_ramWEN", 32'(ramWEN), 1);
        chk("wb1_addr", ramaddr, 32'h104);
        chk("wb1_store", ramstore, 32'h22222222);
        chk("wb1_iwait", 32'(iwait), 1);
        next_cycle; dWEN = 0; ramstate = 2'd0;
        @(negedge CLK);
        chk("wb_idle_ramWEN", 32'(ramWEN), 0);
        chk("wb_cnt", 32'(access_cnt), 3);
        next_cycle; ramstate = 2'd2; ramload = 32'hCAFEF00D;
        @(negedge CLK);
        chk("wb_i_addr", ramaddr, 32'h80);
        chk("wb_i_iload", iload, 32'hCAFEF00D);
        next_cycle; iREN = 0; ramstate = 2'd0;
        @(negedge CLK); chk("wb_i_cnt", 32'(access_cnt), 4);

        // Contention from reset release, dREN and dWEN both high.
        next_cycle; RST = 1;
        next_cycle; RST = 0; iREN = 1; iaddr = 32'h200; dREN = 1; dWEN = 1;
        daddr = 32'h300; ramstate = 2'd2; ramload = 32'h55;
        @(negedge CLK); chk("ct_rst_cnt", 32'(access_cnt), 0);
        next_cycle;
        @(negedge CLK);
        chk("ct_d0_ramWEN", 32'(ramWEN), 1);
        chk("ct_d0_ramREN", 32'(ramREN), 0);
        chk("ct_d0_dload", dload, 32'h55);
        next_cycle;
        next_cycle;
        @(negedge CLK); chk("ct_idle_iwait", 32'(iwait), 1);
        next_cycle;
        @(negedge CLK);
        chk("ct_i_ramaddr", ramaddr, 32'h200);
        chk("ct_i_iwait", 32'(iwait), 0);
        next_cycle; iREN = 0;
        next_cycle;
        @(negedge CLK); chk("ct_d_again_addr", ramaddr, 32'h300);
        next_cycle; dWEN = 0;
        @(negedge CLK);
        chk("ct_rd_ramREN", 32'(ramREN), 1);
        chk("ct_rd_ramWEN", 32'(ramWEN), 0);
        next_cycle; dREN = 0; ramstate = 2'd0;

        // Reset during a dcache block after one beat.
        next_cycle; dWEN = 1; daddr = 32'h400; ramstate = 2'd2;
        next_cycle;
        next_cycle; RST = 1;
        @(negedge CLK); chk("rb_pre_ramWEN", 32'(ramWEN), 1);
        next_cycle; RST = 0; dWEN = 0;
        @(negedge CLK);
        chk("rb_ramWEN", 32'(ramWEN), 0);
        chk("rb_dwait", 32'(dwait), 1);
        chk("rb_cnt", 32'(access_cnt), 0);

        // Stall on BUSY/ERROR, then early release by dropping dREN.
        next_cycle; dREN = 1; daddr = 32'h500; ramstate = 2'd1;
        next_cycle;
        @(negedge CLK); chk("st_busy_dwait", 32'(dwait), 1);
        next_cycle; ramstate = 2'd3;
        @(negedge CLK); chk("st_err_dwait", 32'(dwait), 1);
        next_cycle; ramstate = 2'd2; ramload = 32'h77;
        @(negedge CLK);
        chk("st_acc_dwait", 32'(dwait), 0);
        chk("st_dload", dload, 32'h77);
        next_cycle; dREN = 0; ramstate = 2'd0;
        @(negedge CLK); chk("st_drop_ramREN", 32'(ramREN), 0);
        next_cycle;

        // 17 single-word icache reads wrap the 4-bit counter to 1.
        next_cycle; RST = 1;
        next_cycle; RST = 0; iREN = 1; ramstate = 2'd2; iaddr = 32'h600;
        repeat (33) next_cycle;
        next_cycle; iREN = 0; ramstate = 2'd0;
        @(negedge CLK); chk("wrap_cnt", 32'(access_cnt), 1);
        next_cycle;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 The block SHALL have parameter BLOCK_WORDS, default 2, giving the words per dcache block transfer before arbitration reopens.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the access counter.
REQ-003 The block SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have ports iREN (in, 1), iaddr (in, 32), iwait (out, 1) and iload (out, 32): the icache read request, address, stall and data.
REQ-006 The block SHALL have ports dREN (in, 1), dWEN (in, 1), daddr (in, 32), dstore (in, 32), dwait (out, 1) and dload (out, 32): the dcache request, address, write data, stall and read data.
REQ-007 The block SHALL have ports ramREN (out, 1), ramWEN (out, 1), ramaddr (out, 32), ramstore (out, 32), ramload (in, 32) and ramstate (in, 2): the RAM port; ramstate encodes FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-008 The block SHALL have port access_cnt, output, CNT_W bits: the count of completed RAM accesses.

Function
REQ-009 The block SHALL have states IDLE, DGRANT and IGRANT, held in a registered state variable.
REQ-010 From IDLE, the block SHALL go to DGRANT if dREN|dWEN is high, else to IGRANT if iREN is high, else stay in IDLE.
REQ-011 Exception to REQ-010: if the previous grant was DGRANT and iREN and dREN|dWEN are both high, IDLE SHALL go to IGRANT (anti-starvation); the flag SHALL clear when IGRANT is entered.
REQ-012 In IDLE, ramREN and ramWEN SHALL be 0, iwait and dwait SHALL be 1, and iload and dload SHALL be 0.
REQ-013 In DGRANT, ramaddr SHALL equal daddr and ramstore SHALL equal dstore.
REQ-014 In DGRANT with dWEN high, ramWEN SHALL be 1 and ramREN SHALL be 0.
REQ-015 In DGRANT with dWEN low and dREN high, ramREN SHALL be 1 and ramWEN SHALL be 0.
REQ-016 In DGRANT, dload SHALL equal ramload combinationally.
REQ-017 In DGRANT, dwait SHALL be 0 only in a cycle where ramstate==ACCESS, and 1 otherwise.
REQ-018 In DGRANT, iwait SHALL be 1.
REQ-019 In DGRANT, a 2-bit-or-wider beat counter SHALL increment on each ACCESS cycle.
REQ-020 DGRANT SHALL go to IDLE at the edge where the beat counter reaches BLOCK_WORDS, or at any edge where dREN|dWEN is low.
REQ-021 The beat counter SHALL clear whenever the block leaves DGRANT.
REQ-022 While in DGRANT, changes of daddr between beats SHALL NOT release the grant; this keeps a 2-word block atomic.
REQ-023 In IGRANT, ramREN SHALL be 1, ramWEN SHALL be 0, ramaddr SHALL equal iaddr, and iload SHALL equal ramload.
REQ-024 In IGRANT, iwait SHALL be 0 only when ramstate==ACCESS.
REQ-025 In IGRANT, dwait SHALL be 1.
REQ-026 IGRANT SHALL return to IDLE after one ACCESS cycle, or at any edge where iREN is low.
REQ-027 ramstate BUSY, FREE or ERROR during a grant SHALL keep the requester's wait high and hold the state; no timeout is applied.
REQ-028 access_cnt SHALL increment by 1 on each ACCESS cycle in DGRANT or IGRANT, and wrap modulo 2^CNT_W.
REQ-029 Request-to-first-RAM-drive latency SHALL be 1 cycle (the IDLE arbitration cycle).
REQ-030 Minimum single-word turnaround SHALL be 2 cycles when the RAM returns ACCESS immediately.

Reset
REQ-031 On a rising CLK edge with RST=1, the block SHALL set state=IDLE, beat counter=0, anti-starvation flag=0 and access_cnt=0.
REQ-032 Outputs SHALL take their IDLE values in the cycle after a reset edge, including when reset is asserted mid-transfer.
REQ-033 A transfer interrupted by reset SHALL NOT be resumed.

Verification
REQ-034 Icache read: iREN=1, iaddr=0x40, RAM returns ACCESS on the 3rd cycle with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x40 from cycle 2, iwait=0 and iload=0xDEADBEEF in the ACCESS cycle, access_cnt=1.
REQ-035 Dcache 2-word writeback: dWEN=1, daddr 0x100 then 0x104, ramstate ACCESS each cycle -> ramWEN=1 for 2 cycles, dwait low twice, then IDLE; an iREN raised mid-block is not granted until after the block.
REQ-036 Contention: iREN and dREN are both high from reset release -> DGRANT block first, then IGRANT; after icache completes, pending dREN is granted.
REQ-037 dREN=dWEN=1 in DGRANT -> ramWEN=1, ramREN=0.
REQ-038 RST=1 asserted during DGRANT after 1 beat -> next cycle state=IDLE, ramWEN=0, dwait=1, access_cnt=0.
REQ-039 Counter wrap: with CNT_W=4, 17 single-word icache accesses -> access_cnt=1.
